// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the fetch/decode control slice.
//   - state_e       : fetch controller FSM states
//   - OPC_*         : RV32I major opcodes that matter for operand usage
//   - NOP_INSTR     : canonical NOP (addi x0, x0, 0)
//   - BOOT_PC       : base PC during boot so that the first fetch lands on 0x0
//   - sat_inc16     : saturating 16-bit increment for event counters
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] BOOT_PC    = 32'hFFFF_FFFC;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        if (val == 16'hFFFF) begin
            sat_inc16 = val;
        end else begin
            sat_inc16 = val + 16'd1;
        end
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use hazard check.
// Ports:
//   instr      in  32  instruction entering decode
//   rd_ex      in  5   destination register of the instruction in EX
//   memread_ex in  1   instruction in EX is a load
//   hazard     out 1   decode reads a register the load in EX has not produced yet
module hazard_detect
    import cpu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [4:0]  rd_ex,
    input  logic        memread_ex,
    output logic        hazard
);

    logic [6:0] opcode_s;
    logic [4:0] rs1_s;
    logic [4:0] rs2_s;
    logic       rs1_used_s;
    logic       rs2_used_s;
    logic       unused_instr_s;

    assign opcode_s = instr[6:0];
    assign rs1_s    = instr[19:15];
    assign rs2_s    = instr[24:20];

    // Fields that never participate in the comparison.
    assign unused_instr_s = ^{instr[31:25], instr[14:7]};

    // Decide which source fields are real register reads for this opcode.
    always_comb begin
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b0;
        case (opcode_s)
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                rs1_used_s = 1'b0;
                rs2_used_s = 1'b0;
            end
            OPC_OP, OPC_STORE, OPC_BRANCH: begin
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b1;
            end
            default: begin
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b0;
            end
        endcase
    end

    // x0 is never a real dependency, so rd_ex == 0 cannot hazard.
    always_comb begin
        if (memread_ex && (rd_ex != 5'd0)) begin
            hazard = (rs1_used_s && (rs1_s == rd_ex)) ||
                     (rs2_used_s && (rs2_s == rd_ex));
        end else begin
            hazard = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch/decode pipeline controller.
// Handles boot, load-use stalls and taken-branch flushes.
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   PC_fetch  in  32    PC in the fetch output register
//   IR_fetch  in  32    instruction in the fetch output register
//   RD_ex     in  5     destination register of the EX instruction
//   MEMREAD_ex in 1     EX instruction is a load
//   COMP_alu  in  1     branch/jump taken, resolved in EX
//   PC_prev   out 32    base PC handed back to fetch
//   STALL_dec out 1     hold the decode input register
//   FLUSH_dec out 1     replace decode input with a NOP
//   BUBBLE_ex out 1     insert a NOP into EX
//   STALL_cnt out 16    saturating load-use stall count
//   FLUSH_cnt out 16    saturating taken-branch flush count
module fetch_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_fetch,
    input  logic [31:0] IR_fetch,
    input  logic [4:0]  RD_ex,
    input  logic        MEMREAD_ex,
    input  logic        COMP_alu,
    output logic [31:0] PC_prev,
    output logic        STALL_dec,
    output logic        FLUSH_dec,
    output logic        BUBBLE_ex,
    output logic [15:0] STALL_cnt,
    output logic [15:0] FLUSH_cnt
);

    state_e      state_r;
    state_e      cur_state_s;
    state_e      next_state_s;
    logic        hazard_s;
    logic        stall_inc_s;
    logic        flush_inc_s;
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    hazard_detect u_hazard_detect (
        .instr      (IR_fetch),
        .rd_ex      (RD_ex),
        .memread_ex (MEMREAD_ex),
        .hazard     (hazard_s)
    );

    // Outputs mirror boot values as soon as rst is seen, not one edge later.
    assign cur_state_s = rst ? ST_BOOT : state_r;

    // Next-state and control decode.
    always_comb begin
        next_state_s = ST_BOOT;
        PC_prev      = PC_fetch;
        STALL_dec    = 1'b0;
        FLUSH_dec    = 1'b0;
        BUBBLE_ex    = 1'b0;
        stall_inc_s  = 1'b0;
        flush_inc_s  = 1'b0;
        case (cur_state_s)
            ST_BOOT: begin
                PC_prev      = BOOT_PC;
                FLUSH_dec    = 1'b1;
                BUBBLE_ex    = 1'b1;
                next_state_s = ST_RUN;
            end
            ST_RUN: begin
                // A taken branch makes any pending hazard irrelevant.
                if (COMP_alu) begin
                    FLUSH_dec    = 1'b1;
                    BUBBLE_ex    = 1'b1;
                    flush_inc_s  = 1'b1;
                    next_state_s = ST_FLUSH;
                end else if (hazard_s) begin
                    // Fetch adds 4, so hand back PC-4 to refetch the same PC.
                    PC_prev      = PC_fetch - 32'd4;
                    STALL_dec    = 1'b1;
                    BUBBLE_ex    = 1'b1;
                    stall_inc_s  = 1'b1;
                    next_state_s = ST_STALL;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_STALL: begin
                next_state_s = ST_RUN;
            end
            ST_FLUSH: begin
                next_state_s = ST_RUN;
            end
            default: begin
                PC_prev      = BOOT_PC;
                FLUSH_dec    = 1'b1;
                BUBBLE_ex    = 1'b1;
                next_state_s = ST_BOOT;
            end
        endcase
    end

    // State register and saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_BOOT;
            stall_cnt_r <= 16'd0;
            flush_cnt_r <= 16'd0;
        end else begin
            state_r <= next_state_s;
            if (stall_inc_s) begin
                stall_cnt_r <= sat_inc16(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_inc_s) begin
                flush_cnt_r <= sat_inc16(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign STALL_cnt = stall_cnt_r;
    assign FLUSH_cnt = flush_cnt_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed-vector bench for fetch_ctrl.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] PC_fetch;
    logic [31:0] IR_fetch;
    logic [4:0]  RD_ex;
    logic        MEMREAD_ex;
    logic        COMP_alu;
    logic [31:0] PC_prev;
    logic        STALL_dec;
    logic        FLUSH_dec;
    logic        BUBBLE_ex;
    logic [15:0] STALL_cnt;
    logic [15:0] FLUSH_cnt;

    int n_vec;
    int n_err;

    // Hand-encoded RV32I instructions
    localparam logic [31:0] I_ADD_RS1 = 32'h0072_8333; // add  x6, x5, x7
    localparam logic [31:0] I_ADD_RS2 = 32'h0053_8333; // add  x6, x7, x5
    localparam logic [31:0] I_ADDI_R2 = 32'h0053_8313; // addi x6, x7, 5   (rs2 field = 5, unused)
    localparam logic [31:0] I_LUI_X5  = 32'h0002_82B7; // lui  x5, 0x28    (rs1 field = 5, unused)
    localparam logic [31:0] I_AUIPC   = 32'h0002_8097; // auipc x1, 0x28   (rs1 field = 5, unused)
    localparam logic [31:0] I_SW_RS2  = 32'h0053_A023; // sw   x5, 0(x7)
    localparam logic [31:0] I_ADDI_X0 = 32'h0010_0093; // addi x1, x0, 1

    fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .PC_fetch   (PC_fetch),
        .IR_fetch   (IR_fetch),
        .RD_ex      (RD_ex),
        .MEMREAD_ex (MEMREAD_ex),
        .COMP_alu   (COMP_alu),
        .PC_prev    (PC_prev),
        .STALL_dec  (STALL_dec),
        .FLUSH_dec  (FLUSH_dec),
        .BUBBLE_ex  (BUBBLE_ex),
        .STALL_cnt  (STALL_cnt),
        .FLUSH_cnt  (FLUSH_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic [31:0] pc,
                             input logic st, input logic fl, input logic bu);
        check_vec({tag, ".pc"},     PC_prev,           pc);
        check_vec({tag, ".stall"},  {31'd0, STALL_dec}, {31'd0, st});
        check_vec({tag, ".flush"},  {31'd0, FLUSH_dec}, {31'd0, fl});
        check_vec({tag, ".bubble"}, {31'd0, BUBBLE_ex}, {31'd0, bu});
    endtask

    task automatic check_cnt(input string tag, input logic [15:0] sc, input logic [15:0] fc);
        check_vec({tag, ".scnt"}, {16'd0, STALL_cnt}, {16'd0, sc});
        check_vec({tag, ".fcnt"}, {16'd0, FLUSH_cnt}, {16'd0, fc});
    endtask

    // Drive inputs just after an edge, then let combinational outputs settle.
    task automatic drive(input logic [31:0] pc, input logic [31:0] ir,
                         input logic [4:0] rd, input logic mr, input logic cp);
        PC_fetch   = pc;
        IR_fetch   = ir;
        RD_ex      = rd;
        MEMREAD_ex = mr;
        COMP_alu   = cp;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        drive(32'h0000_0100, I_ADD_RS1, 5'd5, 1'b1, 1'b1);
        tick();
        tick();

        // Reset held: boot outputs regardless of hazard/branch inputs
        check_ctl("rst_hold", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1);
        check_cnt("rst_hold", 16'd0, 16'd0);

        // Reset release: one boot cycle, then RUN
        rst = 1'b0;
        drive(32'h0000_0000, I_ADDI_X0, 5'd0, 1'b0, 1'b0);
        check_ctl("boot", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1);
        tick();
        drive(32'h0000_0000, I_ADDI_X0, 5'd0, 1'b0, 1'b0);
        check_ctl("run0", 32'h0000_0000, 1'b0, 1'b0, 1'b0);

        // Load-use on rs1
        drive(32'h0000_0010, I_ADD_RS1, 5'd5, 1'b1, 1'b0);
        check_ctl("lu_rs1", 32'h0000_000C, 1'b1, 1'b0, 1'b1);
        tick();
        check_cnt("lu_rs1", 16'd1, 16'd0);
        // STALL cycle ignores both hazard and branch
        drive(32'h0000_0010, I_ADD_RS1, 5'd5, 1'b1, 1'b1);
        check_ctl("stall_cyc", 32'h0000_0010, 1'b0, 1'b0, 1'b0);
        tick();
        check_cnt("stall_cyc", 16'd1, 16'd0);

        // No false hazards: x0, unused rs2 field, LUI/AUIPC rs1 field, no load
        drive(32'h0000_0014, I_ADDI_X0, 5'd0, 1'b1, 1'b0);
        check_ctl("nh_x0", 32'h0000_0014, 1'b0, 1'b0, 1'b0);
        drive(32'h0000_0014, I_ADDI_R2, 5'd5, 1'b1, 1'b0);
        check_ctl("nh_addi", 32'h0000_0014, 1'b0, 1'b0, 1'b0);
        drive(32'h0000_0014, I_LUI_X5, 5'd5, 1'b1, 1'b0);
        check_ctl("nh_lui", 32'h0000_0014, 1'b0, 1'b0, 1'b0);
        drive(32'h0000_0014, I_AUIPC, 5'd5, 1'b1, 1'b0);
        check_ctl("nh_auipc", 32'h0000_0014, 1'b0, 1'b0, 1'b0);
        drive(32'h0000_0014, I_ADD_RS1, 5'd5, 1'b0, 1'b0);
        check_ctl("nh_noload", 32'h0000_0014, 1'b0, 1'b0, 1'b0);
        tick();
        check_cnt("nh", 16'd1, 16'd0);

        // Load-use on rs2 (R-type)
        drive(32'h0000_0020, I_ADD_RS2, 5'd5, 1'b1, 1'b0);
        check_ctl("lu_rs2", 32'h0000_001C, 1'b1, 1'b0, 1'b1);
        tick();
        check_cnt("lu_rs2", 16'd2, 16'd0);
        drive(32'h0000_0020, I_ADDI_X0, 5'd0, 1'b0, 1'b0);
        tick();

        // Load-use on store data (rs2 of STORE)
        drive(32'h0000_0030, I_SW_RS2, 5'd5, 1'b1, 1'b0);
        check_ctl("lu_sw", 32'h0000_002C, 1'b1, 1'b0, 1'b1);
        tick();
        check_cnt("lu_sw", 16'd3, 16'd0);
        drive(32'h0000_0030, I_ADDI_X0, 5'd0, 1'b0, 1'b0);
        tick();

        // Taken branch, then branch ignored in FLUSH cycle
        drive(32'h0000_0040, I_ADDI_X0, 5'd0, 1'b0, 1'b1);
        check_ctl("br", 32'h0000_0040, 1'b0, 1'b1, 1'b1);
        tick();
        check_cnt("br", 16'd3, 16'd1);
        drive(32'h0000_0080, I_ADDI_X0, 5'd0, 1'b0, 1'b1);
        check_ctl("flush_cyc", 32'h0000_0080, 1'b0, 1'b0, 1'b0);
        tick();
        check_cnt("flush_cyc", 16'd3, 16'd1);

        // Branch and hazard together: branch wins
        drive(32'h0000_0084, I_ADD_RS1, 5'd5, 1'b1, 1'b1);
        check_ctl("br_hz", 32'h0000_0084, 1'b0, 1'b1, 1'b1);
        tick();
        check_cnt("br_hz", 16'd3, 16'd2);
        drive(32'h0000_0100, I_ADD_RS1, 5'd5, 1'b1, 1'b0);
        check_ctl("br_hz_fl", 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        tick();
        check_cnt("br_hz_fl", 16'd3, 16'd2);

        // Saturation: preload stall counter at all-ones, then stall
        force dut.stall_cnt_r = 16'hFFFF;
        #1;
        release dut.stall_cnt_r;
        drive(32'h0000_0200, I_ADD_RS1, 5'd5, 1'b1, 1'b0);
        check_cnt("sat_pre", 16'hFFFF, 16'd2);
        check_ctl("sat_stall", 32'h0000_01FC, 1'b1, 1'b0, 1'b1);
        tick();
        check_cnt("sat", 16'hFFFF, 16'd2);

        // Reset mid-STALL: boot outputs immediately, counters cleared at edge
        rst = 1'b1;
        drive(32'h0000_0200, I_ADD_RS1, 5'd5, 1'b1, 1'b1);
        check_ctl("rst_stall", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1);
        tick();
        check_cnt("rst_stall", 16'd0, 16'd0);
        rst = 1'b0;
        drive(32'h0000_0000, I_ADDI_X0, 5'd0, 1'b0, 1'b0);
        check_ctl("reboot", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1);
        tick();
        drive(32'h0000_0000, I_ADD_RS1, 5'd5, 1'b1, 1'b0);
        check_ctl("rerun_hz", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1);
        tick();
        check_cnt("rerun_hz", 16'd1, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
